button_hold_detector: RTL and testbench

Debounces the keypad's dedicated reset/clear push-button and classifies each press as short or long. A long press generates the hold request that drives the lock's reset-extension logic; a short press is reported separately for the lock FSM, for example as a clear-entry action. The block runs on the 1 kHz system clock alongside the other lock timing blocks.

---
 rtl/button_hold_detector_if.sv | 25 ++
 rtl/button_hold_detector.sv | 155 +++++++++++++++
 tb/tb_button_hold_detector.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/button_hold_detector_if.sv
// Button-side signal bundle for button_hold_detector: raw button in, debounced level and press events out.
// The master drives the raw button; the slave (the detector) drives the classified outputs.
interface button_hold_detector_if;
   logic btn_raw;
   logic btn_level;
   logic press_pulse;
   logic hold_pulse;
   logic hold_active;

   modport master (
      output btn_raw,
      input  btn_level,
      input  press_pulse,
      input  hold_pulse,
      input  hold_active
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output press_pulse,
      output hold_pulse,
      output hold_active
   );
endinterface

// File: rtl/button_hold_detector.sv
// Debounces the keypad clear button and classifies each press as short (press_pulse) or long (hold_pulse).
// Define BTN_ACTIVE_LOW_EN for a button input that reads 0 when pressed.
module button_hold_detector #(
   parameter int CLK_FREQ_HZ = 1000,
   parameter int DEBOUNCE_MS = 20,
   parameter int HOLD_S      = 5
) (
   input  logic                   clk,
   input  logic                   reset_in,
   button_hold_detector_if.slave  bus
);
   localparam int DEBOUNCE_CYCLES = DEBOUNCE_MS * CLK_FREQ_HZ / 1000;
   localparam int HOLD_CYCLES     = HOLD_S * CLK_FREQ_HZ;
   localparam int DB_W            = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W          = $clog2(HOLD_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESSED,
      ST_HELD
   } state_t;

   // The synchronizer carries the raw pin polarity; its reset value is always "released".
`ifdef BTN_ACTIVE_LOW_EN
   localparam logic SYNC_RST = 1'b1;
`else
   localparam logic SYNC_RST = 1'b0;
`endif

   logic              r_sync1;
   logic              r_sync2;
   logic              w_btn_sync;
   logic [DB_W-1:0]   r_db_cnt;
   logic              r_level;
   logic              w_level_next;
   logic              w_rise;
   logic              w_fall;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              w_hold_reach;
   state_t            r_state;
   state_t            w_state_next;
   logic              w_press_next;
   logic              w_hold_next;
   logic              r_press_pulse;
   logic              r_hold_pulse;
   logic              r_hold_active;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_sync1 <= SYNC_RST;
         r_sync2 <= SYNC_RST;
      end else begin
         r_sync1 <= bus.btn_raw;
         r_sync2 <= r_sync1;
      end
   end

`ifdef BTN_ACTIVE_LOW_EN
   assign w_btn_sync = ~r_sync2;
`else
   assign w_btn_sync = r_sync2;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_level_next = r_level;
      if ((w_btn_sync != r_level) && (r_db_cnt == DB_MAX)) begin
         w_level_next = ~r_level;
      end
   end

   assign w_rise = ~r_level & w_level_next;
   assign w_fall = r_level & ~w_level_next;

   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_db_cnt <= '0;
         r_level  <= 1'b0;
      end else begin
         r_level <= w_level_next;
         if ((w_btn_sync == r_level) || (r_db_cnt == DB_MAX)) begin
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_hold_cnt <= '0;
      end else if (w_rise) begin
         r_hold_cnt <= '0;
      end else if (r_level && (r_hold_cnt != HOLD_MAX)) begin
         r_hold_cnt <= r_hold_cnt + 1'b1;
      end
   end

   // The count lands on HOLD_CYCLES at this edge; a simultaneous release still takes priority below.
   assign w_hold_reach = r_level && (r_hold_cnt == HOLD_PRE);

   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_state       <= ST_IDLE;
         r_press_pulse <= 1'b0;
         r_hold_pulse  <= 1'b0;
         r_hold_active <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_press_pulse <= w_press_next;
         r_hold_pulse  <= w_hold_next;
         r_hold_active <= (w_state_next == ST_HELD);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_press_next = 1'b0;
      w_hold_next  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_next = ST_PRESSED;
            end
         end
         ST_PRESSED: begin
            if (w_fall) begin
               w_state_next = ST_IDLE;
               w_press_next = 1'b1;
            end else if (w_hold_reach) begin
               w_state_next = ST_HELD;
               w_hold_next  = 1'b1;
            end
         end
         ST_HELD: begin
            if (w_fall) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.btn_level   = r_level;
   assign bus.press_pulse = r_press_pulse;
   assign bus.hold_pulse  = r_hold_pulse;
   assign bus.hold_active = r_hold_active;
endmodule

// File: tb/tb_button_hold_detector.sv
// Randomized scoreboard bench for button_hold_detector: a sample-history model predicts every output event.
// Build with BTN_ACTIVE_LOW_EN defined to exercise the pressed-low input polarity.
module tb_button_hold_detector;
   localparam int DEB  = 2;
   localparam int HOLD = 1000;

`ifdef BTN_ACTIVE_LOW_EN
   localparam logic PRESSED_LVL = 1'b0;
`else
   localparam logic PRESSED_LVL = 1'b1;
`endif

   typedef enum int {EV_RISE, EV_HOLD, EV_ACT_UP, EV_FALL, EV_ACT_DN, EV_PRESS} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       cyc;
   } ev_t;

   logic clk = 1'b0;
   logic reset_in;
   int   cyc   = -1;
   int   tests = 0;
   int   fails = 0;
   bit   mon_on = 1'b0;

   ev_t  exp_q[$];
   bit   hist[$];
   bit   m_level = 1'b0;
   bit   m_held  = 1'b0;
   int   m_rise_cyc = 0;
   bit   prev_level = 1'b0;
   bit   prev_act   = 1'b0;

   button_hold_detector_if bus_if ();

   button_hold_detector #(
      .CLK_FREQ_HZ (1000),
      .DEBOUNCE_MS (2),
      .HOLD_S      (1)
   ) dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic void push_ev(ev_kind_t k);
      ev_t e;
      e.kind = k;
      e.cyc  = cyc;
      exp_q.push_back(e);
   endfunction

   // Model: the level flips once DEB+1 consecutive synchronized samples disagree with it;
   // a press is long once the level has stayed high for HOLD cycles.
   always @(posedge clk) begin
      bit smp;
      bit all_diff;
      cyc++;
      smp = (bus_if.btn_raw === PRESSED_LVL);
      hist.push_back(smp);
      if (reset_in === 1'b1) begin
         hist[cyc] = 1'b0;
         if (cyc > 0) hist[cyc-1] = 1'b0;
         if (m_level) push_ev(EV_FALL);
         if (m_held)  push_ev(EV_ACT_DN);
         m_level = 1'b0;
         m_held  = 1'b0;
      end else begin
         all_diff = (cyc >= DEB + 2);
         for (int k = 2; k <= DEB + 2; k++) begin
            if (all_diff && (hist[cyc-k] == m_level)) all_diff = 1'b0;
         end
         if (all_diff && !m_level) begin
            m_level    = 1'b1;
            m_rise_cyc = cyc;
            push_ev(EV_RISE);
         end else if (all_diff && m_level) begin
            m_level = 1'b0;
            push_ev(EV_FALL);
            if (m_held) push_ev(EV_ACT_DN);
            else        push_ev(EV_PRESS);
            m_held = 1'b0;
         end else if (m_level && !m_held && (cyc - m_rise_cyc == HOLD)) begin
            m_held = 1'b1;
            push_ev(EV_HOLD);
            push_ev(EV_ACT_UP);
         end
      end
   end

   task automatic expect_ev(ev_kind_t k);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL event: got %s at cycle %0d, expected no event", k.name(), cyc);
      end else begin
         e = exp_q.pop_front();
         if ((e.kind != k) || (e.cyc != cyc)) begin
            fails++;
            $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                     k.name(), cyc, e.kind.name(), e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if ((bus_if.btn_level === 1'b1) && !prev_level)   expect_ev(EV_RISE);
         if (bus_if.hold_pulse === 1'b1)                   expect_ev(EV_HOLD);
         if ((bus_if.hold_active === 1'b1) && !prev_act)   expect_ev(EV_ACT_UP);
         if ((bus_if.btn_level !== 1'b1) && prev_level)    expect_ev(EV_FALL);
         if ((bus_if.hold_active !== 1'b1) && prev_act)    expect_ev(EV_ACT_DN);
         if (bus_if.press_pulse === 1'b1)                  expect_ev(EV_PRESS);
         prev_level = (bus_if.btn_level === 1'b1);
         prev_act   = (bus_if.hold_active === 1'b1);
      end
   end

   task automatic drive(bit pressed, int n);
      bus_if.btn_raw = pressed ? PRESSED_LVL : ~PRESSED_LVL;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(int n);
      reset_in = 1'b1;
      repeat (n) begin
         @(negedge clk);
         check("outputs_in_reset",
               {28'd0, bus_if.btn_level, bus_if.press_pulse, bus_if.hold_pulse, bus_if.hold_active},
               32'd0);
      end
      reset_in = 1'b0;
   endtask

   initial begin
      int len;
      reset_in       = 1'b1;
      bus_if.btn_raw = ~PRESSED_LVL;
      do_reset(1);
      mon_on = 1'b1;
      do_reset(2);
      drive(1'b0, 20);

      // Short press, then long press.
      drive(1'b1, 100);
      drive(1'b0, 30);
      drive(1'b1, 1500);
      drive(1'b0, 30);

      // Single-cycle glitches, then a bouncy edge followed by a stable press.
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1);
         drive(1'b0, 2);
      end
      drive(1'b0, 20);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1);
         drive(1'b0, 1);
      end
      drive(1'b1, 200);
      drive(1'b0, 30);

      // Release landing exactly on the hold point, then one cycle later.
      drive(1'b1, HOLD);
      drive(1'b0, 30);
      drive(1'b1, HOLD + 1);
      drive(1'b0, 30);

      // Reset about halfway through a press while the button stays down.
      drive(1'b1, 504);
      do_reset(1);
      drive(1'b1, 1200);
      drive(1'b0, 30);

      // Random press/release segments with occasional short bounces and resets.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 3);
         else                           len = $urandom_range(5, 1200);
         drive(i[0] == 1'b0, len);
         if ($urandom_range(0, 11) == 0) do_reset($urandom_range(1, 2));
      end

      drive(1'b0, 40);
      check("pending_events", exp_q.size(), 0);
      check("idle_outputs",
            {28'd0, bus_if.btn_level, bus_if.press_pulse, bus_if.hold_pulse, bus_if.hold_active},
            32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
